// File: rtl/pipe_full_pkg.sv
// rtl/pipe_full_pkg.sv - shared constants and stage record for the skewed pipelined adder
//
// Purpose: default operand width and the per-stage record that travels down
//          the pipeline. Record fields are sized to PF_MAX_W so the same type
//          serves any WIDTH up to PF_MAX_W; only the low WIDTH bits carry data.
package pipe_full_pkg;

    localparam int PF_WIDTH = 4;
    localparam int PF_MAX_W = 32;

    typedef logic [PF_MAX_W-1:0] pf_word_t;

    // One pipeline slot: valid flag, sum/carry bits produced so far, and the
    // operand bits still waiting for their stage.
    typedef struct packed {
        logic     valid;
        pf_word_t sum;
        pf_word_t carry;
        pf_word_t a;
        pf_word_t b;
    } pf_stage_t;

endpackage

// File: rtl/pipe_full_fa.sv
// rtl/pipe_full_fa.sv - combinational one-bit full adder
//
// Purpose: single bit of the ripple chain.
// Ports:
//   a_i, b_i  operand bits
//   c_i       carry in
//   s_o       sum bit
//   c_o       carry out (majority of the three inputs)
module pipe_full_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/pipe_full.sv
// rtl/pipe_full.sv - bit-serial-skewed pipelined ripple-carry adder
//
// Purpose: stage k adds bit k of its own operand set using the carry that
//          stage k-1 registered one cycle earlier. Latency is WIDTH edges,
//          one new operation accepted every cycle, no backpressure.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   a/b/cin sampled this cycle
//   a, b       addends (WIDTH bits)
//   cin        carry into bit 0
//   out_valid  sum/carry hold a result completed this cycle
//   sum        sum bits of a+b+cin
//   carry      per-bit carry-outs; carry[WIDTH-1] is the final carry
module pipe_full
    import pipe_full_pkg::*;
#(
    parameter int WIDTH = PF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    pf_stage_t        stage_q [WIDTH];
    pf_stage_t        stage_d [WIDTH];

    // feed[k] is the record arriving at stage k this cycle.
    pf_stage_t        feed    [WIDTH];

    logic [WIDTH-1:0] fa_a;
    logic [WIDTH-1:0] fa_b;
    logic [WIDTH-1:0] fa_ci;
    logic [WIDTH-1:0] fa_s;
    logic [WIDTH-1:0] fa_co;

    // Stage 0 is fed from the ports; later stages from the previous register.
    // Carry-in of stage k is the carry bit k-1 that its own operand set
    // produced in the previous stage, so each set stays with its own carry.
    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            feed[k] = '0;
        end
        fa_ci          = '0;
        feed[0].valid  = in_valid;
        feed[0].a      = pf_word_t'(a);
        feed[0].b      = pf_word_t'(b);
        fa_ci[0]       = cin;
        for (int k = 1; k < WIDTH; k++) begin
            feed[k]  = stage_q[k-1];
            fa_ci[k] = stage_q[k-1].carry[k-1];
        end
        for (int k = 0; k < WIDTH; k++) begin
            fa_a[k] = feed[k].a[k];
            fa_b[k] = feed[k].b[k];
        end
    end

    for (genvar k = 0; k < WIDTH; k++) begin : g_fa
        pipe_full_fa u_fa (
            .a_i (fa_a[k]),
            .b_i (fa_b[k]),
            .c_i (fa_ci[k]),
            .s_o (fa_s[k]),
            .c_o (fa_co[k])
        );
    end

    // Valid always advances; data only loads behind a valid slot, so a bubble
    // leaves the previous result parked in every stage it passes.
    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            stage_d[k]       = stage_q[k];
            stage_d[k].valid = feed[k].valid;
            if (feed[k].valid) begin
                stage_d[k]          = feed[k];
                stage_d[k].sum[k]   = fa_s[k];
                stage_d[k].carry[k] = fa_co[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < WIDTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < WIDTH; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign out_valid = stage_q[WIDTH-1].valid;
    assign sum       = stage_q[WIDTH-1].sum[WIDTH-1:0];
    assign carry     = stage_q[WIDTH-1].carry[WIDTH-1:0];

endmodule

// File: tb/tb_pipe_full.sv
// tb/tb_pipe_full.sv - directed and randomized checks of the pipelined adder
module tb_pipe_full;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       out_valid;
    logic [3:0] sum;
    logic [3:0] carry;

    int n_cmp = 0;
    int n_err = 0;

    logic [4:0] exp_q[$];
    logic [4:0] exp_v;
    int         issued;

    always #5 clk = ~clk;

    pipe_full #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
        .carry     (carry)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] av, input logic [3:0] bv, input logic cv);
        in_valid = v;
        a        = av;
        b        = bv;
        cin      = cv;
    endtask

    // Single isolated operation: issue, then three idle edges.
    task automatic single(input string tag, input logic [3:0] av, input logic [3:0] bv,
                          input logic cv, input logic [3:0] es, input logic [3:0] ec);
        drive(1'b1, av, bv, cv);
        tick();
        drive(1'b0, 4'h0, 4'h0, 1'b0);
        tick();
        tick();
        chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_sum"},   32'(sum),       32'(es));
        chk({tag, "_carry"}, 32'(carry),     32'(ec));
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 1'b0);
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sum",   32'(sum),       32'd0);
        chk("rst_carry", 32'(carry),     32'd0);
        rst = 1'b0;

        single("c_a_c0", 4'b1100, 4'b1010, 1'b0, 4'b0110, 4'b1000);
        single("c_a_c1", 4'b1100, 4'b1010, 1'b1, 4'b0111, 4'b1000);
        single("f_1_c0", 4'b1111, 4'b0001, 1'b0, 4'b0000, 4'b1111);
        single("f_f_c1", 4'b1111, 4'b1111, 1'b1, 4'b1111, 4'b1111);

        // Back-to-back burst, bubble, one more.
        drive(1'b1, 4'b0000, 4'b0000, 1'b1); tick();
        drive(1'b1, 4'b0101, 4'b1010, 1'b0); tick();
        drive(1'b1, 4'b1111, 4'b0001, 1'b0); tick();
        drive(1'b0, 4'b0000, 4'b0000, 1'b0); tick();
        chk("b2b0_valid", 32'(out_valid),   32'd1);
        chk("b2b0_out",   32'({sum, carry}), 32'h10);
        drive(1'b1, 4'b0011, 4'b0011, 1'b0); tick();
        chk("b2b1_valid", 32'(out_valid),   32'd1);
        chk("b2b1_out",   32'({sum, carry}), 32'hF0);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0); tick();
        chk("b2b2_valid", 32'(out_valid),   32'd1);
        chk("b2b2_out",   32'({sum, carry}), 32'h0F);
        tick();
        chk("bub_valid",  32'(out_valid),   32'd0);
        chk("bub_hold",   32'({sum, carry}), 32'h0F);
        tick();
        chk("b2b4_valid", 32'(out_valid),   32'd1);
        chk("b2b4_out",   32'({sum, carry}), 32'h63);
        tick();
        chk("idle_valid", 32'(out_valid),   32'd0);
        chk("idle_hold",  32'({sum, carry}), 32'h63);

        // Reset mid-flight, then a new operation on the first edge out of reset.
        drive(1'b1, 4'b1111, 4'b0001, 1'b0); tick();
        drive(1'b1, 4'b0101, 4'b1010, 1'b0); tick();
        rst = 1'b1;
        drive(1'b0, 4'b0000, 4'b0000, 1'b0); tick();
        chk("mrst_valid", 32'(out_valid),   32'd0);
        chk("mrst_out",   32'({sum, carry}), 32'd0);
        rst = 1'b0;
        drive(1'b1, 4'b0011, 4'b0001, 1'b1); tick();
        drive(1'b0, 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("post_valid", 32'(out_valid),   32'd0);
            chk("post_out",   32'({sum, carry}), 32'd0);
            tick();
        end
        chk("post_valid", 32'(out_valid),   32'd0);
        chk("post_out",   32'({sum, carry}), 32'd0);
        tick();
        chk("new_valid",  32'(out_valid),   32'd1);
        chk("new_out",    32'({sum, carry}), 32'h53);

        // Randomized traffic against a+b+cin, in issue order.
        issued = 0;
        while (issued < 1000) begin
            drive(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 1'($urandom));
            if (in_valid) begin
                exp_q.push_back(5'(a) + 5'(b) + 5'(cin));
                issued++;
            end
            tick();
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected", 32'(out_valid), 32'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    chk("rnd_sum", 32'({carry[3], sum}), 32'(exp_v));
                end
            end
        end
        drive(1'b0, 4'h0, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected", 32'(out_valid), 32'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    chk("rnd_sum", 32'({carry[3], sum}), 32'(exp_v));
                end
            end
        end
        chk("rnd_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
